floor_request_queue: RTL and testbench
======================================

Name: floor_request_queue

Overview:
- Ordered FIFO of pending elevator floor requests.
- Sits directly upstream of floor_comparator: head entry drives comparator input pos0Mem.
- Accepts button requests, optionally drops duplicates, and pops the head when the motion controller reports service of that floor complete.
- When empty, presents actualFloor on pos0Mem so the downstream comparator reports stop (stop_goFlag=1).

Parameters:
- DEPTH, 4, number of queue entries (power of 2, >=2).
- FLOOR_W, 2, floor index width (matches comparator ports).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- reqValid  input  1  one-cycle request strobe from button decoder.
- reqFloor  input  FLOOR_W  requested floor, sampled when reqValid=1.
- popReq  input  1  one-cycle strobe: head floor served (doors closed).
- actualFloor  input  FLOOR_W  current cabin floor.
- pos0Mem  output  FLOOR_W  head entry, or actualFloor when empty.
- pos0Valid  output  1  1 when queue non-empty.
- count  output  clog2(DEPTH)+1  number of stored entries.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- reqDropped  output  1  registered pulse: last request rejected (full or duplicate).

Behaviour:
- Storage: DEPTH x FLOOR_W register array, write pointer wrPtr and read pointer rdPtr (clog2(DEPTH) bits, natural wrap), count register.
- Reset (async, rst_n=0): wrPtr=0, rdPtr=0, count=0, reqDropped=0, array cleared to 0. Outputs therefore: empty=1, full=0, pos0Valid=0, pos0Mem=actualFloor. Reset mid-operation discards all pending requests immediately.
- pos0Mem/pos0Valid/full/empty: combinational from registered state (array[rdPtr], count). Latency: request pushed at edge N into an empty queue is visible on pos0Mem after edge N.
- Push accept condition: reqValid=1 and (count<DEPTH or pop accepted same cycle) and not duplicate. Accepted: array[wrPtr]<=reqFloor, wrPtr+1.
- Pop accept condition: popReq=1 and count>0; rdPtr+1. popReq on empty ignored, no state change, not flagged.
- Simultaneous push+pop: both accepted, count unchanged. Includes full case (push uses slot freed by pop) and empty case (pop ignored, push accepted, count 0->1).
- count: +1 push only, -1 pop only, unchanged otherwise; never exceeds DEPTH or goes below 0.
- reqDropped: registered; set to 1 the cycle after a rejected reqValid, otherwise 0.
- Request equal to actualFloor is still queued; the comparator then stops immediately and the controller pops it.

Optional Feature:
- DUPLICATE_FILTER_EN defined:
  - Request is a duplicate if reqFloor equals any valid stored entry. Valid entries are the count entries from rdPtr.
  - The head being popped in the same cycle is excluded from the match, so that request is accepted.
  - Duplicates are not stored; reqDropped pulses.
- DUPLICATE_FILTER_EN undefined: no filtering. Duplicates are stored as separate entries; only full causes a drop.

Decomposition:
- Shared package elevator_pkg:
  - FLOOR_W=2, NUM_FLOORS=4.
  - typedef floor_t (logic [FLOOR_W-1:0]).
  - QUEUE_DEPTH default 4.
  - This package is also reused by floor_comparator's successors.
- One sub-module: floor_request_match. Purely combinational; compares reqFloor against the array under a valid-entry mask and outputs a match bit. Instantiated only under DUPLICATE_FILTER_EN.

Test Plan:
- Reset then idle, actualFloor=2 -> empty=1, count=0, pos0Mem=2, pos0Valid=0.
- Push floors 3,1,0 on consecutive cycles -> count=3. pos0Mem=3 one cycle after the first push. Pop -> pos0Mem=1, count=2.
- Fill to 4 entries (0,1,2,3), then push 2 alone -> dropped, reqDropped=1 next cycle, count=4. Push 2 with popReq same cycle -> accepted, count=4, order 1,2,3,2 (filter off) or drop (filter on, 2 still stored).
- DUPLICATE_FILTER_EN: queue {1,3}, push 3 -> dropped, count=2. Queue {1,3}, push 1 with popReq -> accepted, queue {3,1}.
- Pointer wrap: 10 push/pop cycles at DEPTH=4 -> FIFO order preserved, count never exceeds 4. popReq while empty -> no change, count=0.
- Assert rst_n low mid-sequence with count=3 -> immediate empty=1, pos0Mem=actualFloor. Next push after release -> count=1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator constants and types, reused by the request queue and the
// floor comparator family.
package elevator_pkg;

  localparam int FLOOR_W     = 2;
  localparam int NUM_FLOORS  = 4;
  localparam int QUEUE_DEPTH = 4;

  typedef logic [FLOOR_W-1:0] floor_t;

endpackage : elevator_pkg

// File: rtl/floor_request_match.sv
// Combinational duplicate detector: flags when the requested floor equals any
// stored entry whose bit is set in the valid mask.
module floor_request_match #(
  parameter int DEPTH   = 4,
  parameter int FLOOR_W = 2
) (
  input  logic [FLOOR_W-1:0] reqFloor,
  input  logic [FLOOR_W-1:0] entries [DEPTH],
  input  logic [DEPTH-1:0]   validMask,
  output logic               match
);

  logic [DEPTH-1:0] hit;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit[gi] = validMask[gi] && (entries[gi] == reqFloor);
    end
  endgenerate

  assign match = |hit;

endmodule : floor_request_match

// File: rtl/floor_request_queue.sv
// Ordered FIFO of pending floor requests; the head drives the comparator's pos0Mem.
// Define DUPLICATE_FILTER_EN to reject requests already waiting in the queue.
module floor_request_queue
  import elevator_pkg::*;
#(
  parameter int DEPTH   = QUEUE_DEPTH,
  parameter int FLOOR_W = elevator_pkg::FLOOR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reqValid,
  input  logic [FLOOR_W-1:0]       reqFloor,
  input  logic                     popReq,
  input  logic [FLOOR_W-1:0]       actualFloor,
  output logic [FLOOR_W-1:0]       pos0Mem,
  output logic                     pos0Valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     reqDropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [FLOOR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               dropped_q, dropped_d;
  logic               pop_acc, push_acc, dup_hit;

  assign empty      = (count_q == '0);
  assign full       = (count_q == DEPTH_C);
  assign pos0Valid  = !empty;
  assign count      = count_q;
  assign reqDropped = dropped_q;
  // An empty queue presents the cabin floor so the comparator reports stop.
  assign pos0Mem    = empty ? actualFloor : mem_q[rd_ptr_q];

`ifdef DUPLICATE_FILTER_EN
  logic [DEPTH-1:0] valid_mask;

  // Slot is live if its distance from the head is below count; the head being
  // popped this cycle is excluded so a request for it is accepted again.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
      logic [PTR_W-1:0] offset;
      assign offset = PTR_W'(gi) - rd_ptr_q;
      assign valid_mask[gi] = ({1'b0, offset} < count_q) && !(pop_acc && (offset == '0));
    end
  endgenerate

  floor_request_match #(
    .DEPTH   (DEPTH),
    .FLOOR_W (FLOOR_W)
  ) u_match (
    .reqFloor  (reqFloor),
    .entries   (mem_q),
    .validMask (valid_mask),
    .match     (dup_hit)
  );
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    pop_acc   = popReq && !empty;
    push_acc  = reqValid && (!full || pop_acc) && !dup_hit;
    dropped_d = reqValid && !push_acc;
    wr_ptr_d  = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_acc  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      if (push_acc) begin
        mem_q[wr_ptr_q] <= reqFloor;
      end
    end
  end

endmodule : floor_request_queue

// File: tb/tb_floor_request_queue.sv
// Randomized and directed bench for floor_request_queue, checked every cycle
// against a queue-based model of the request FIFO.
module tb_floor_request_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reqValid;
  logic [1:0] reqFloor;
  logic       popReq;
  logic [1:0] actualFloor;
  logic [1:0] pos0Mem;
  logic       pos0Valid;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       reqDropped;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  int q[$];
  bit drop_m = 1'b0;

  floor_request_queue #(.DEPTH(DEPTH), .FLOOR_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqValid    (reqValid),
    .reqFloor    (reqFloor),
    .popReq      (popReq),
    .actualFloor (actualFloor),
    .pos0Mem     (pos0Mem),
    .pos0Valid   (pos0Valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .reqDropped  (reqDropped)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Queue semantics: pop the head if any, drop duplicates still waiting
  // (ignoring the head that leaves this cycle), append if room remains.
  task automatic model_step(bit v, int f, bit p);
    bit pop, dup, push;
    pop = p && (q.size() > 0);
    dup = 1'b0;
`ifdef DUPLICATE_FILTER_EN
    for (int i = (pop ? 1 : 0); i < q.size(); i++) begin
      if (q[i] == f) dup = 1'b1;
    end
`endif
    push = v && ((q.size() < DEPTH) || pop) && !dup;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(f);
    drop_m = v && !push;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("count", int'(count), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("pos0Valid", int'(pos0Valid), int'(q.size() != 0));
      chk("pos0Mem", int'(pos0Mem), (q.size() != 0) ? q[0] : int'(actualFloor));
      chk("reqDropped", int'(reqDropped), int'(drop_m));
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(bit v, int f, bit p);
    reqValid = v;
    reqFloor = 2'(f);
    popReq   = p;
    @(posedge clk);
    model_step(v, f, p);
    @(negedge clk);
    reqValid = 1'b0;
    popReq   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    drop_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    reqValid = 1'b0;
    reqFloor = 2'd0;
    popReq = 1'b0;
    actualFloor = 2'd2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset then idle
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_pos0Mem", int'(pos0Mem), 2);
    chk("rst_pos0Valid", int'(pos0Valid), 0);

    // Push 3,1,0 then pop
    cycle(1, 3, 0);
    chk("first_push_head", int'(pos0Mem), 3);
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    chk("three_count", int'(count), 3);
    cycle(0, 0, 1);
    chk("pop_head", int'(pos0Mem), 1);
    chk("pop_count", int'(count), 2);

    // Fill 0,1,2,3 then overflow
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, i, 0);
    chk("fill_full", int'(full), 1);
    cycle(1, 2, 0);
    chk("ovf_dropped", int'(reqDropped), 1);
    chk("ovf_count", int'(count), 4);
    cycle(1, 2, 1);
`ifdef DUPLICATE_FILTER_EN
    chk("fullpop_dropped", int'(reqDropped), 1);
    chk("fullpop_count", int'(count), 3);
`else
    chk("fullpop_dropped", int'(reqDropped), 0);
    chk("fullpop_count", int'(count), 4);
    chk("fullpop_head", int'(pos0Mem), 1);
    cycle(0, 0, 1);
    chk("order_2", int'(pos0Mem), 2);
    cycle(0, 0, 1);
    chk("order_3", int'(pos0Mem), 3);
    cycle(0, 0, 1);
    chk("order_last2", int'(pos0Mem), 2);
`endif

`ifdef DUPLICATE_FILTER_EN
    do_reset();
    cycle(1, 1, 0);
    cycle(1, 3, 0);
    cycle(1, 3, 0);
    chk("dup_dropped", int'(reqDropped), 1);
    chk("dup_count", int'(count), 2);
    cycle(1, 1, 1);
    chk("headdup_dropped", int'(reqDropped), 0);
    chk("headdup_head", int'(pos0Mem), 3);
    cycle(0, 0, 1);
    chk("headdup_tail", int'(pos0Mem), 1);
`endif

    // Pointer wrap and empty pop
    do_reset();
    cycle(1, 1, 0);
    cycle(1, 2, 0);
    for (int i = 0; i < 10; i++) cycle(1, (i + 3) % 4, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("wrap_drain", int'(count), 0);
    cycle(0, 0, 1);
    chk("empty_pop_count", int'(count), 0);
    chk("empty_pop_drop", int'(reqDropped), 0);

    // Reset mid-operation
    cycle(1, 3, 0);
    cycle(1, 0, 0);
    cycle(1, 2, 0);
    chk("pre_rst_count", int'(count), 3);
    actualFloor = 2'd1;
    #2;
    rst_n = 1'b0;
    q.delete();
    drop_m = 1'b0;
    #1;
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_pos0Mem", int'(pos0Mem), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1, 2, 0);
    chk("post_rst_count", int'(count), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) actualFloor = 2'($urandom_range(0, 3));
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_floor_request_queue
